// File: rtl/nco_pkg.sv
// Shared types for the NCO bank: sequencer states, the config-write bundle and
// the CORDIC arctangent table expressed in fractions of a full turn.
package nco_pkg;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} nco_state_t;

  localparam int CFG_CH_W    = 4;   // covers up to 16 channels
  localparam int CFG_PHASE_W = 32;  // widest supported phase word

  typedef struct packed {
    logic [CFG_CH_W-1:0]    ch;
    logic [CFG_PHASE_W-1:0] inc;
    logic [CFG_PHASE_W-1:0] offset;
    logic                   sync;
  } cfg_wr_t;

  // atan(2^-i) scaled so that 2^32 is one full turn
  function automatic logic [31:0] cordic_atan_turns(input int idx);
    case (idx)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      default: return 32'd683565276 >> idx;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Pipelined rotation-mode CORDIC: angle (fraction of a turn) to sin/cos.
// Latency is STAGES + 2 cycles: input register, STAGES rotations, output register.
module cordic_rotator
  import nco_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int STAGES     = 12,
  parameter int ANGLE_W    = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ANGLE_W-1:0]           angle,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out
);

  localparam int GUARD = 4;
  localparam int IW    = DATA_WIDTH + GUARD + 1;
  localparam int ZW    = ANGLE_W;
  localparam int MAXV  = 2 ** (DATA_WIDTH - 1) - 1;
  // Start vector pre-divided by the CORDIC gain (1/1.64676 ~ 39797/65536)
  localparam longint X_INIT_L = (longint'(MAXV) * (2 ** GUARD) * 39797 + 32768) / 65536;
  localparam logic signed [IW-1:0] X_INIT = IW'(X_INIT_L);
  localparam logic signed [IW-1:0] RND    = IW'(2 ** (GUARD - 1));

  logic signed [IW-1:0]         x_reg [0:STAGES];
  logic signed [IW-1:0]         y_reg [0:STAGES];
  logic signed [ZW-1:0]         z_reg [0:STAGES-1];
  logic [1:0]                   q_reg [0:STAGES];
  logic signed [IW-1:0]         x_rnd, y_rnd;
  logic signed [DATA_WIDTH-1:0] x_sat, y_sat;

  function automatic logic signed [ZW-1:0] atan_step(input int i);
    return ZW'(cordic_atan_turns(i) >> (32 - ANGLE_W));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > MAXV)  return DATA_WIDTH'(MAXV);
    if (v < -MAXV) return DATA_WIDTH'(-MAXV);
    return DATA_WIDTH'(v);
  endfunction

  always_comb begin
    x_rnd = (x_reg[STAGES] + RND) >>> GUARD;
    y_rnd = (y_reg[STAGES] + RND) >>> GUARD;
    x_sat = sat(x_rnd);
    y_sat = sat(y_rnd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= STAGES; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
        q_reg[i] <= '0;
      end
      for (int i = 0; i < STAGES; i++) z_reg[i] <= '0;
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      // Quadrant is handled by a final swap; the core only sees [0, 90 deg)
      x_reg[0] <= X_INIT;
      y_reg[0] <= '0;
      z_reg[0] <= {2'b00, angle[ANGLE_W-3:0]};
      q_reg[0] <= angle[ANGLE_W-1 -: 2];
      for (int i = 0; i < STAGES; i++) begin
        if (z_reg[i][ZW-1]) begin
          x_reg[i+1] <= x_reg[i] + (y_reg[i] >>> i);
          y_reg[i+1] <= y_reg[i] - (x_reg[i] >>> i);
        end else begin
          x_reg[i+1] <= x_reg[i] - (y_reg[i] >>> i);
          y_reg[i+1] <= y_reg[i] + (x_reg[i] >>> i);
        end
        q_reg[i+1] <= q_reg[i];
      end
      for (int i = 0; i < STAGES - 1; i++)
        z_reg[i+1] <= z_reg[i][ZW-1] ? z_reg[i] + atan_step(i) : z_reg[i] - atan_step(i);
      case (q_reg[STAGES])
        2'd0:    begin cos_out <= x_sat;  sin_out <= y_sat;  end
        2'd1:    begin cos_out <= -y_sat; sin_out <= x_sat;  end
        2'd2:    begin cos_out <= -x_sat; sin_out <= -y_sat; end
        default: begin cos_out <= y_sat;  sin_out <= -x_sat; end
      endcase
    end
  end

endmodule

// File: rtl/nco_bank.sv
// Multi-channel NCO: per-channel phase accumulators with double-buffered config,
// issued one channel per cycle into a single shared CORDIC on each sample tick.
module nco_bank
  import nco_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PHASE_W    = 32,
  parameter int ANGLE_W    = 20,
  parameter int DATA_W     = 12,
  parameter int CORDIC_LAT = 14,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic signed [PHASE_W-1:0] cfg_inc,
  input  logic [PHASE_W-1:0]        cfg_offset,
  input  logic                      cfg_sync,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_ch,
  output logic signed [DATA_W-1:0]  sin_out,
  output logic signed [DATA_W-1:0]  cos_out,
  output logic                      overrun
);

  nco_state_t          state_reg;
  logic [CH_W-1:0]     ch_reg;
  logic                overrun_reg;
  cfg_wr_t             cfg_wr;
  logic                commit, issue;
  logic [PHASE_W-1:0]  acc_vec [NUM_CH];
  logic [PHASE_W-1:0]  inc_vec [NUM_CH];
  logic [PHASE_W-1:0]  off_vec [NUM_CH];
  logic [PHASE_W-1:0]  sel_acc, sel_off, phase_sum;
  logic [ANGLE_W-1:0]  issue_angle;
  logic [CORDIC_LAT-1:0] vld_pipe_reg;
  logic [CH_W-1:0]     ch_pipe_reg [CORDIC_LAT];

  assign cfg_wr = '{ch:     CFG_CH_W'(cfg_ch),
                    inc:    CFG_PHASE_W'(cfg_inc),
                    offset: CFG_PHASE_W'(cfg_offset),
                    sync:   cfg_sync};

  assign cfg_ready = (state_reg == IDLE);
  assign commit    = cfg_ready && sample_tick;
  assign issue     = (state_reg == ISSUE);
  assign overrun   = overrun_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PHASE_W-1:0] acc_reg, inc_reg, off_reg, sh_inc_reg, sh_off_reg;
    logic               sync_pend_reg;
    logic               hit, eff_sync;
    logic [PHASE_W-1:0] eff_inc, eff_off;

    // A write in the tick cycle lands in the shadow first so the commit sees it
    assign hit      = cfg_valid && cfg_ready && (cfg_wr.ch == CFG_CH_W'(gi));
    assign eff_inc  = hit ? cfg_wr.inc[PHASE_W-1:0]    : sh_inc_reg;
    assign eff_off  = hit ? cfg_wr.offset[PHASE_W-1:0] : sh_off_reg;
    assign eff_sync = sync_pend_reg || (hit && cfg_wr.sync);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_reg       <= '0;
        inc_reg       <= '0;
        off_reg       <= '0;
        sh_inc_reg    <= '0;
        sh_off_reg    <= '0;
        sync_pend_reg <= 1'b0;
      end else begin
        sh_inc_reg <= eff_inc;
        sh_off_reg <= eff_off;
        if (commit) begin
          inc_reg       <= eff_inc;
          off_reg       <= eff_off;
          sync_pend_reg <= 1'b0;
          if (eff_sync) acc_reg <= '0;
        end else begin
          sync_pend_reg <= eff_sync;
          if (issue && ch_reg == CH_W'(gi)) acc_reg <= acc_reg + inc_reg;
        end
      end
    end

    assign acc_vec[gi] = acc_reg;
    assign inc_vec[gi] = inc_reg;
    assign off_vec[gi] = off_reg;
  end

  always_comb begin
    sel_acc = acc_vec[0];
    sel_off = off_vec[0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_reg == CH_W'(c)) begin
        sel_acc = acc_vec[c];
        sel_off = off_vec[c];
      end
    end
    phase_sum   = sel_acc + sel_off;
    issue_angle = ANGLE_W'(phase_sum >> (PHASE_W - ANGLE_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            state_reg <= ISSUE;
            ch_reg    <= '0;
          end
        end
        default: begin
          if (sample_tick) overrun_reg <= 1'b1;
          if (ch_reg == CH_W'(NUM_CH - 1)) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
          end else begin
            ch_reg <= ch_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Tag pipe depth must equal the CORDIC latency so out_ch lines up with data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_reg <= '0;
      for (int i = 0; i < CORDIC_LAT; i++) ch_pipe_reg[i] <= '0;
    end else begin
      vld_pipe_reg <= {vld_pipe_reg[CORDIC_LAT-2:0], issue};
      ch_pipe_reg[0] <= ch_reg;
      for (int i = 1; i < CORDIC_LAT; i++) ch_pipe_reg[i] <= ch_pipe_reg[i-1];
    end
  end

  assign out_valid = vld_pipe_reg[CORDIC_LAT-1];
  assign out_ch    = ch_pipe_reg[CORDIC_LAT-1];

  cordic_rotator #(
    .DATA_WIDTH (DATA_W),
    .STAGES     (DATA_W),
    .ANGLE_W    (ANGLE_W)
  ) u_cordic (
    .clk     (clk),
    .rst     (rst),
    .angle   (issue_angle),
    .sin_out (sin_out),
    .cos_out (cos_out)
  );

endmodule

// File: tb/tb_nco_bank.sv
// Directed bench for nco_bank: tick sequencing, config commit, sync, overrun and reset.
module tb_nco_bank;

  localparam int NUM_CH = 4;
  localparam int LAT    = 14;
  localparam int MAXV   = 2047;
  localparam int TOL    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_ch;
  logic signed [31:0] cfg_inc;
  logic [31:0]        cfg_offset;
  logic               cfg_sync;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [11:0] sin_out;
  logic signed [11:0] cos_out;
  logic               overrun;

  int n_vec = 0;
  int n_bad = 0;
  int n_valid, first_k, tick_no;
  int ch_seq [8];
  int sin_by_ch [NUM_CH];
  int cos_by_ch [NUM_CH];
  int exp_sin0 [4];
  int exp_cos0 [4];
  int exp_cos2 [4];
  int stray;

  always #5 clk = ~clk;

  nco_bank dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_inc     (cfg_inc),
    .cfg_offset  (cfg_offset),
    .cfg_sync    (cfg_sync),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .sin_out     (sin_out),
    .cos_out     (cos_out),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got < exp - tol || got > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] inc, input logic [31:0] off,
                           input logic sync);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_inc    = inc;
    cfg_offset = off;
    cfg_sync   = sync;
    check("cfg_ready", int'(cfg_ready), 1, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_sync  = 1'b0;
  endtask

  // Raise one tick (optionally a second one dbl_k cycles later) and collect outputs
  task automatic run_tick(input int dbl_k);
    n_valid = 0;
    first_k = -1;
    for (int c = 0; c < NUM_CH; c++) begin
      sin_by_ch[c] = 99999;
      cos_by_ch[c] = 99999;
    end
    sample_tick = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sample_tick = (k == dbl_k);
      cfg_valid   = 1'b0;
      cfg_sync    = 1'b0;
      if (out_valid) begin
        if (first_k < 0) first_k = k;
        if (n_valid < 8) ch_seq[n_valid] = int'(out_ch);
        sin_by_ch[out_ch] = int'(sin_out);
        cos_by_ch[out_ch] = int'(cos_out);
        n_valid++;
      end
    end
    tick_no++;
    $display("tick %0d: %0d valid, first at +%0d, sin=%0d/%0d/%0d/%0d cos=%0d/%0d/%0d/%0d ovr=%0b",
             tick_no, n_valid, first_k, sin_by_ch[0], sin_by_ch[1], sin_by_ch[2], sin_by_ch[3],
             cos_by_ch[0], cos_by_ch[1], cos_by_ch[2], cos_by_ch[3], overrun);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, n_valid, NUM_CH, 0);
    for (int c = 0; c < NUM_CH; c++) check({tag, "_ch_order"}, ch_seq[c], c, 0);
  endtask

  initial begin
    tick_no = 0;
    exp_sin0 = '{0, MAXV, 0, -MAXV};
    exp_cos0 = '{MAXV, 0, -MAXV, 0};
    exp_cos2 = '{MAXV, 1447, 0, -1447};
    rst = 1'b1; sample_tick = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_inc = '0; cfg_offset = '0; cfg_sync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_sin", int'(sin_out), 0, 0);
    check("rst_cos", int'(cos_out), 0, 0);
    check("rst_out_ch", int'(out_ch), 0, 0);
    check("rst_overrun", int'(overrun), 0, 0);
    check("rst_cfg_ready", int'(cfg_ready), 1, 0);
    rst = 1'b0;
    @(negedge clk);

    // ch0 quarter-turn steps, ch1 fixed 90 deg offset, ch2 eighth-turn steps
    cfg_write(0, 32'h4000_0000, 32'h0, 1'b0);
    cfg_write(1, 32'h0, 32'h4000_0000, 1'b0);
    cfg_write(2, 32'h2000_0000, 32'h0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      run_tick(0);
      check_seq("quad");
      check("first_latency", first_k, 1 + LAT, 0);
      check("ch0_sin", sin_by_ch[0], exp_sin0[t], TOL);
      check("ch0_cos", cos_by_ch[0], exp_cos0[t], TOL);
      check("ch1_sin", sin_by_ch[1], MAXV, TOL);
      check("ch1_cos", cos_by_ch[1], 0, TOL);
      check("ch2_cos", cos_by_ch[2], exp_cos2[t], TOL);
      check("no_overrun", int'(overrun), 0, 0);
    end

    // Second tick two cycles into the sequence is dropped
    run_tick(2);
    check_seq("overrun");
    check("overrun_set", int'(overrun), 1, 0);

    // Sync clears ch2 phase at the next commit
    cfg_write(2, 32'h2000_0000, 32'h0, 1'b1);
    run_tick(0);
    check("sync_ch2_sin", sin_by_ch[2], 0, TOL);
    check("sync_ch2_cos", cos_by_ch[2], MAXV, TOL);
    run_tick(0);
    check("sync_ch2_sin45", sin_by_ch[2], 1447, TOL);
    check("sync_ch2_cos45", cos_by_ch[2], 1447, TOL);

    // Config written in the tick cycle takes effect on that tick
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 32'h4000_0000; cfg_offset = '0; cfg_sync = 1'b0;
    check("same_cyc_ready", int'(cfg_ready), 1, 0);
    run_tick(0);
    check("same_cyc_ch3_sin0", sin_by_ch[3], 0, TOL);
    check("same_cyc_ch3_cos0", cos_by_ch[3], MAXV, TOL);
    run_tick(0);
    check("same_cyc_ch3_sin1", sin_by_ch[3], MAXV, TOL);
    check("same_cyc_ch3_cos1", cos_by_ch[3], 0, TOL);

    // Reset in the middle of an issue sequence
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(out_valid), 0, 0);
    check("mid_rst_sin", int'(sin_out), 0, 0);
    check("mid_rst_cos", int'(cos_out), 0, 0);
    check("mid_rst_out_ch", int'(out_ch), 0, 0);
    check("mid_rst_overrun", int'(overrun), 0, 0);
    check("mid_rst_cfg_ready", int'(cfg_ready), 1, 0);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("post_rst_no_valid", stray, 0, 0);
    run_tick(0);
    check_seq("post_rst");
    check("post_rst_ch0_cos", cos_by_ch[0], MAXV, TOL);
    check("post_rst_ch3_sin", sin_by_ch[3], 0, TOL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nco_bank.md
NCO_BANK -- requirements
Module: nco_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent NCO channels, 1..16.
REQ-002 SHALL have parameter PHASE_W, default 32: phase accumulator, increment and offset width.
REQ-003 SHALL have parameter ANGLE_W, default 20: angle width passed to the CORDIC, taken as the top bits of the phase; ANGLE_W <= PHASE_W.
REQ-004 SHALL have parameter DATA_W, default 12: sin/cos output width and CORDIC stage count.
REQ-005 SHALL have parameter CORDIC_LAT, default 14: clock latency of cordic_rotator, angle in to sin/cos out.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port sample_tick, input, 1: one-cycle strobe that starts one output sample per channel.
REQ-009 SHALL have port cfg_valid, input, 1: configuration write request.
REQ-010 SHALL have port cfg_ready, output, 1: configuration write accepted when high together with cfg_valid.
REQ-011 SHALL have port cfg_ch, input, $clog2(NUM_CH) (min 1): channel to configure.
REQ-012 SHALL have port cfg_inc, input, PHASE_W, signed: new phase increment.
REQ-013 SHALL have port cfg_offset, input, PHASE_W: new phase offset.
REQ-014 SHALL have port cfg_sync, input, 1: clear this channel's accumulator at commit.
REQ-015 SHALL have port out_valid, output, 1: sample output valid.
REQ-016 SHALL have port out_ch, output, $clog2(NUM_CH): channel of the current output sample.
REQ-017 SHALL have ports sin_out and cos_out, output, DATA_W, signed: sample values.
REQ-018 SHALL have port overrun, output, 1: sticky flag, set when a sample_tick arrives while busy.

Function
REQ-019 SHALL keep per channel an active register set (acc, inc, offset) and a shadow register set (inc, offset, sync_pending).
REQ-020 SHALL drive cfg_ready high only in state IDLE; an accepted write loads the shadow inc and offset and ORs cfg_sync into sync_pending.
REQ-021 SHALL use FSM states IDLE and ISSUE; on sample_tick in IDLE, go to ISSUE with the channel counter at 0.
REQ-022 SHALL, on the IDLE->ISSUE transition, copy every shadow set into its active set, clear acc for channels with sync_pending, then clear all sync_pending.
REQ-023 SHALL, in ISSUE, issue one channel per cycle, ch = 0..NUM_CH-1, then return to IDLE after ch NUM_CH-1.
REQ-024 SHALL compute the issued angle as (acc + offset) mod 2^PHASE_W, bits [PHASE_W-1 -: ANGLE_W], and update acc <= acc + inc (wrapping) in the same cycle.
REQ-025 SHALL use the post-commit (sync-cleared) acc for the first issue after a commit.
REQ-026 SHALL carry a valid/channel tag through a CORDIC_LAT-deep shift register, so out_valid and out_ch align exactly with the CORDIC result.
REQ-027 SHALL give the first sin_out/cos_out of a tick at cycle T+1+CORDIC_LAT, where T is the tick cycle, with NUM_CH consecutive valid cycles.
REQ-028 SHALL, on sample_tick during ISSUE, drop the tick, set overrun, and leave the sequence undisturbed.
REQ-029 SHALL, when cfg_valid is high in the same cycle as sample_tick in IDLE, accept the write before the commit, so it takes effect in that tick.
REQ-030 SHALL treat negative inc as reverse rotation by two's-complement wrap.

Reset
REQ-031 SHALL, on rst, clear all acc, inc, offset, shadow registers, sync_pending, channel counter, valid pipe, out_ch, sin_out, cos_out and overrun, and enter IDLE.
REQ-032 SHALL discard an in-flight sequence on rst; no out_valid SHALL follow until a new tick.

Structure
REQ-033 SHALL place the FSM state enum and a cfg-write struct (ch, inc, offset, sync) in shared package nco_pkg.
REQ-034 SHALL instantiate exactly one cordic_rotator (DATA_WIDTH=DATA_W, STAGES=DATA_W), time-shared by all channels.

Verification
REQ-035 SHALL test: ch0 inc=2^30, offset=0, 4 ticks -> ch0 sin about 0, +max, 0, -max, each within ±4 LSB of the cordic_rotator spec.
REQ-036 SHALL test: ch1 offset=2^30 with inc=0 -> cos_out about 0 and sin_out about +max on every tick.
REQ-037 SHALL test: a sample_tick 2 cycles after a tick, NUM_CH=4 -> overrun=1 and exactly 4 valid outputs for ch 0..3.
REQ-038 SHALL test: cfg_sync on ch2 mid-run, then a tick -> the first ch2 sample has angle 0 (sin about 0, cos about +max).
REQ-039 SHALL test: cfg write and sample_tick in the same cycle -> the new inc is used on that tick's first acc update.
REQ-040 SHALL test: rst asserted during ISSUE -> all outputs 0, no out_valid until the next tick, and cfg_ready=1.
